// File: rtl/mac_frame_pkg.sv
// Shared types and constants for the A/B/C frame link (transmitter and receiver).
package mac_frame_pkg;

    localparam int FRAME_DEPTH = 4;
    localparam int SAMPLE_W    = 8;

    typedef logic [SAMPLE_W-1:0] sample_t;

    // Packed so that slot i of each lane sits at bits [i*SAMPLE_W +: SAMPLE_W],
    // the same layout as the parallel load buses.
    typedef struct packed {
        sample_t [FRAME_DEPTH-1:0] a;
        sample_t [FRAME_DEPTH-1:0] b;
        sample_t [FRAME_DEPTH-1:0] c;
    } frame_t;

    typedef enum logic {IDLE, SEND} tx_state_e;

    // Bundle the three packed load buses into one frame.
    function automatic frame_t pack_frame(
        input logic [FRAME_DEPTH*SAMPLE_W-1:0] a,
        input logic [FRAME_DEPTH*SAMPLE_W-1:0] b,
        input logic [FRAME_DEPTH*SAMPLE_W-1:0] c
    );
        frame_t f;
        f.a = a;
        f.b = b;
        f.c = c;
        return f;
    endfunction

endpackage

// File: rtl/mac_frame_tx_if.sv
// Load handshake plus serial A/B/C output bundle of the frame transmitter.
interface mac_frame_tx_if #(
    parameter int WIDTH = mac_frame_pkg::SAMPLE_W,
    parameter int DEPTH = mac_frame_pkg::FRAME_DEPTH
);
    logic                   load_valid;
    logic                   load_ready;
    logic [DEPTH*WIDTH-1:0] load_a;
    logic [DEPTH*WIDTH-1:0] load_b;
    logic [DEPTH*WIDTH-1:0] load_c;
    logic [WIDTH-1:0]       A;
    logic [WIDTH-1:0]       B;
    logic [WIDTH-1:0]       C;
    logic                   out_valid;
    logic                   frame_start;
    logic [1:0]             slot;
    logic [15:0]            frames_sent;

    // Host / stimulus side.
    modport master (
        output load_valid, load_a, load_b, load_c,
        input  load_ready, A, B, C, out_valid, frame_start, slot, frames_sent
    );

    // Transmitter side.
    modport slave (
        input  load_valid, load_a, load_b, load_c,
        output load_ready, A, B, C, out_valid, frame_start, slot, frames_sent
    );
endinterface

// File: rtl/mac_frame_buf.sv
// Shadow frame register with full flag; owns the load valid/ready handshake.
module mac_frame_buf
    import mac_frame_pkg::*;
(
    input  logic   clock,
    input  logic   reset,
    input  logic   i_valid,
    input  frame_t i_frame,
    input  logic   i_take,
    input  logic   i_bypass,
    output logic   o_ready,
    output logic   o_full,
    output logic   o_accept,
    output frame_t o_frame
);
    logic   r_full;
    logic   r_ready;
    frame_t r_frame;
    logic   w_full_next;

    assign o_accept = i_valid & r_ready;

    // Full flag: drained by the serialiser, set by a handshake unless the
    // frame is routed straight to the active buffer.
    always_comb begin
        w_full_next = r_full;
        if (i_take) begin
            w_full_next = 1'b0;
        end else if (o_accept && !i_bypass) begin
            w_full_next = 1'b1;
        end
    end

    // Storage; ready is registered as the inverse of the next full flag.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_full  <= 1'b0;
            r_ready <= 1'b0;
            r_frame <= '0;
        end else begin
            r_full  <= w_full_next;
            r_ready <= !w_full_next;
            if (o_accept && !i_bypass) begin
                r_frame <= i_frame;
            end
        end
    end

    assign o_ready = r_ready;
    assign o_full  = r_full;
    assign o_frame = r_frame;
endmodule

// File: rtl/mac_frame_tx.sv
// Frame transmitter: accepts a parallel frame and serialises it slot by slot.
module mac_frame_tx
    import mac_frame_pkg::*;
#(
    parameter int WIDTH = SAMPLE_W,
    parameter int DEPTH = FRAME_DEPTH
)(
    input  logic          clock,
    input  logic          reset,
    mac_frame_tx_if.slave io_bus
);
    localparam logic [1:0] LAST_SLOT = 2'(DEPTH - 1);

    tx_state_e        r_state, w_state_next;
    logic [1:0]       r_slot, w_slot_next;
    frame_t           r_active, w_active_next;
    frame_t           w_load_frame, w_shadow;
    logic             w_shadow_full, w_accept, w_ready, w_take, w_bypass;
    logic [WIDTH-1:0] r_a, r_b, r_c, w_a_next, w_b_next, w_c_next;
    logic             r_valid, w_valid_next, r_start, w_start_next;
    logic [15:0]      r_count, w_count_next;

    assign w_load_frame = pack_frame(io_bus.load_a, io_bus.load_b, io_bus.load_c);

    mac_frame_buf u_buf (
        .clock    (clock),
        .reset    (reset),
        .i_valid  (io_bus.load_valid),
        .i_frame  (w_load_frame),
        .i_take   (w_take),
        .i_bypass (w_bypass),
        .o_ready  (w_ready),
        .o_full   (w_shadow_full),
        .o_accept (w_accept),
        .o_frame  (w_shadow)
    );

    // Next state, next active frame and the sample to drive in the next cycle.
    always_comb begin
        w_state_next  = r_state;
        w_slot_next   = r_slot;
        w_active_next = r_active;
        w_count_next  = r_count;
        w_take        = 1'b0;
        w_bypass      = 1'b0;
        w_a_next      = '0;
        w_b_next      = '0;
        w_c_next      = '0;
        w_valid_next  = 1'b0;
        w_start_next  = 1'b0;
        case (r_state)
            IDLE: begin
                w_slot_next = 2'd0;
                if (w_shadow_full) begin
                    w_take        = 1'b1;
                    w_active_next = w_shadow;
                    w_state_next  = SEND;
                end
            end
            SEND: begin
                if (r_slot != LAST_SLOT) begin
                    w_slot_next = r_slot + 2'd1;
                end else begin
                    w_count_next = r_count + 16'd1;
                    w_slot_next  = 2'd0;
                    if (w_shadow_full) begin
                        w_take        = 1'b1;
                        w_active_next = w_shadow;
                    end else if (w_accept) begin
                        // Frame arriving in the last slot skips the shadow.
                        w_bypass      = 1'b1;
                        w_active_next = w_load_frame;
                    end else begin
                        w_state_next = IDLE;
                    end
                end
            end
            default: w_state_next = IDLE;
        endcase
        if (w_state_next == SEND) begin
            w_a_next     = w_active_next.a[w_slot_next];
            w_b_next     = w_active_next.b[w_slot_next];
            w_c_next     = w_active_next.c[w_slot_next];
            w_valid_next = 1'b1;
            w_start_next = (w_slot_next == 2'd0);
        end
    end

    // State, active buffer, frame counter and output registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_slot   <= 2'd0;
            r_active <= '0;
            r_count  <= 16'd0;
            r_a      <= '0;
            r_b      <= '0;
            r_c      <= '0;
            r_valid  <= 1'b0;
            r_start  <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_slot   <= w_slot_next;
            r_active <= w_active_next;
            r_count  <= w_count_next;
            r_a      <= w_a_next;
            r_b      <= w_b_next;
            r_c      <= w_c_next;
            r_valid  <= w_valid_next;
            r_start  <= w_start_next;
        end
    end

    assign io_bus.load_ready  = w_ready;
    assign io_bus.A           = r_a;
    assign io_bus.B           = r_b;
    assign io_bus.C           = r_c;
    assign io_bus.out_valid   = r_valid;
    assign io_bus.frame_start = r_start;
    assign io_bus.slot        = r_slot;
    assign io_bus.frames_sent = r_count;
endmodule

// File: tb/tb_mac_frame_tx.sv
// Bench for mac_frame_tx: directed sequence plus random traffic against a
// timeline model (each accepted frame gets a start edge computed arithmetically).
module tb_mac_frame_tx;

    logic clock;
    logic reset;

    mac_frame_tx_if bus ();

    mac_frame_tx dut (
        .clock  (clock),
        .reset  (reset),
        .io_bus (bus)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        int          hs;   // edge at which the frame was accepted
        int          st;   // edge after which slot 0 is on the outputs
    } mframe_t;

    mframe_t frames[$];
    int      t;            // posedge count
    int      n_cmp;
    int      n_bad;
    int      n_acc;
    int      cnt_base;
    bit      just_reset;
    bit      last_hs;

    // Shadow is occupied from a frame's acceptance until its start edge.
    function automatic bit m_ready();
        if (reset || just_reset) return 1'b0;
        foreach (frames[i]) begin
            if (frames[i].hs <= t && t < frames[i].st) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic int m_slot();
        foreach (frames[i]) begin
            if (frames[i].st <= t && t < frames[i].st + 4) return t - frames[i].st;
        end
        return -1;
    endfunction

    function automatic int m_done();
        int d = 0;
        foreach (frames[i]) begin
            if (frames[i].st + 4 <= t) d++;
        end
        return d;
    endfunction

    task automatic cmp(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        assert (got === exp)
        else begin
            n_bad++;
            $error("FAIL %s at edge %0d: observed %h expected %h", tag, t, got, exp);
        end
    endtask

    task automatic timeout_fail(input string tag);
        n_cmp++;
        n_bad++;
        $error("FAIL %s: 20-cycle bound expired at edge %0d", tag, t);
    endtask

    task automatic check();
        logic [7:0] ea, eb, ec;
        logic       ev, efs;
        logic [1:0] es;
        int         k;
        ea = '0; eb = '0; ec = '0; ev = 1'b0; efs = 1'b0; es = 2'd0;
        foreach (frames[i]) begin
            if (frames[i].st <= t && t < frames[i].st + 4) begin
                k   = t - frames[i].st;
                ea  = frames[i].a[k*8 +: 8];
                eb  = frames[i].b[k*8 +: 8];
                ec  = frames[i].c[k*8 +: 8];
                ev  = 1'b1;
                efs = (k == 0);
                es  = 2'(k);
            end
        end
        cmp("A",           16'(bus.A),           16'(ea));
        cmp("B",           16'(bus.B),           16'(eb));
        cmp("C",           16'(bus.C),           16'(ec));
        cmp("out_valid",   16'(bus.out_valid),   16'(ev));
        cmp("frame_start", 16'(bus.frame_start), 16'(efs));
        cmp("slot",        16'(bus.slot),        16'(es));
        cmp("frames_sent", bus.frames_sent,      16'(cnt_base + m_done()));
        cmp("load_ready",  16'(bus.load_ready),  16'(m_ready()));
    endtask

    // One clock: decide the handshake from the model, advance, then check.
    task automatic step();
        bit      hs;
        int      prev_end;
        mframe_t f;
        hs = (bus.load_valid === 1'b1) && m_ready();
        @(posedge clock);
        t++;
        last_hs = hs;
        if (hs) begin
            prev_end = (frames.size() > 0) ? frames[$].st + 4 : -100;
            f.a  = bus.load_a;
            f.b  = bus.load_b;
            f.c  = bus.load_c;
            f.hs = t;
            f.st = (prev_end >= t) ? prev_end : t + 1;
            frames.push_back(f);
            n_acc++;
            $display("accept #%0d edge %0d start %0d a=%h b=%h c=%h",
                     n_acc, t, f.st, f.a, f.b, f.c);
        end
        if (!reset) just_reset = 1'b0;
        #1 check();
    endtask

    task automatic idle(input int n);
        bus.load_valid = 1'b0;
        repeat (n) step();
    endtask

    task automatic send_frame(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        int n = 0;
        bus.load_valid = 1'b1;
        bus.load_a = a;
        bus.load_b = b;
        bus.load_c = c;
        do begin
            step();
            n++;
        end while (!last_hs && n < 20);
        if (!last_hs) timeout_fail("send_frame");
        bus.load_valid = 1'b0;
    endtask

    task automatic wait_slot(input int k);
        int n = 0;
        while (m_slot() != k && n < 20) begin
            step();
            n++;
        end
        if (m_slot() != k) timeout_fail("wait_slot");
    endtask

    initial begin
        n_cmp = 0; n_bad = 0; n_acc = 0; t = 0; cnt_base = 0;
        just_reset = 1'b1;
        last_hs = 1'b0;
        reset = 1'b1;
        bus.load_valid = 1'b0;
        bus.load_a = '0;
        bus.load_b = '0;
        bus.load_c = '0;

        // Reset state, then release.
        repeat (3) step();
        reset = 1'b0;
        idle(2);

        // Single frame.
        send_frame(32'h04030201, 32'h02020202, 32'h01010101);
        idle(8);

        // Back-to-back frames with valid held.
        for (int j = 0; j < 3; j++) send_frame($urandom, $urandom, $urandom);
        idle(14);

        // Handshake during the last slot with the shadow empty.
        send_frame($urandom, $urandom, $urandom);
        wait_slot(3);
        bus.load_valid = 1'b1;
        bus.load_a = 32'hA4A3A2A1;
        bus.load_b = $urandom;
        bus.load_c = $urandom;
        step();
        bus.load_valid = 1'b0;
        cmp("bypass_frame_start", 16'(bus.frame_start), 16'd1);
        cmp("bypass_first_A",     16'(bus.A),           16'h00A1);
        idle(8);

        // Backpressure: data changes while waiting for ready.
        send_frame($urandom, $urandom, $urandom);
        send_frame($urandom, $urandom, $urandom);
        begin
            int n = 0;
            bus.load_valid = 1'b1;
            bus.load_a = $urandom;
            bus.load_b = $urandom;
            bus.load_c = $urandom;
            do begin
                step();
                n++;
                if (!last_hs) begin
                    bus.load_a = $urandom;
                    bus.load_b = $urandom;
                    bus.load_c = $urandom;
                end
            end while (!last_hs && n < 20);
            if (!last_hs) timeout_fail("backpressure");
            bus.load_valid = 1'b0;
        end
        idle(14);

        // Random traffic with a well-behaved source.
        for (int i = 0; i < 300; i++) begin
            if (!bus.load_valid && ($urandom_range(0, 2) == 0)) begin
                bus.load_valid = 1'b1;
                bus.load_a = $urandom;
                bus.load_b = $urandom;
                bus.load_c = $urandom;
            end
            step();
            if (last_hs) bus.load_valid = 1'b0;
        end
        idle(10);

        // Asynchronous reset during slot 2.
        send_frame($urandom, $urandom, $urandom);
        wait_slot(2);
        #2 reset = 1'b1;
        frames.delete();
        cnt_base = 0;
        just_reset = 1'b1;
        #1 check();
        @(negedge clock);
        reset = 1'b0;
        idle(8);

        // Counter wrap: preset near the top, then complete three frames.
        force dut.r_count = 16'hFFFE;
        cnt_base = 32'hFFFE - m_done();
        step();
        release dut.r_count;
        step();
        for (int j = 0; j < 3; j++) send_frame($urandom, $urandom, $urandom);
        idle(14);
        cmp("wrap_final_count", bus.frames_sent, 16'h0001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
